branch_resolve_unit: RTL and testbench

ID-stage branch interlock and operand source for the pipelined MIPS core. On a beq/bne in ID, it stalls the front end until both branch operands are obtainable, then drives them to the ID-stage 32-bit equality comparator. It consumes the comparator's `is_equal` and issues the taken decision and IF flush. It is the producer/consumer end of the comparator's data1/data2/isEqual interface.

---
 rtl/branch_resolve_unit_pkg.sv | 15 +
 rtl/branch_resolve_unit_hazard_detect.sv | 51 +++++
 rtl/branch_resolve_unit.sv | 117 +++++++++++
 tb/tb_branch_resolve_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the ID-stage branch resolve unit: FSM encoding,
// datapath defaults and stall-counter width.
package branch_resolve_unit_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned RW_DEF = 5;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } brs_state_e;

endpackage

// File: rtl/branch_resolve_unit_hazard_detect.sv
// Combinational branch hazard depth (need) and MEM-stage ALU forwarding
// select for the two branch operands.
module branch_hazard_detect
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [RW-1:0]    ex_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [RW-1:0]    mem_rd,
  input  logic [DW-1:0]    mem_alu_result,
  output logic [CNT_W-1:0] need,
  output logic [DW-1:0]    fwd_a,
  output logic [DW-1:0]    fwd_b
);

  // Cycles a source must wait: EX load 2, EX ALU 1, MEM load 1; r0 never waits.
  function automatic logic [CNT_W-1:0] need_of(input logic [RW-1:0] r);
    need_of = '0;
    if (r != '0) begin
      if (ex_reg_write && (ex_rd == r))
        need_of = ex_mem_read ? CNT_W'(2) : CNT_W'(1);
      else if (mem_reg_write && mem_mem_read && (mem_rd == r))
        need_of = CNT_W'(1);
    end
  endfunction

  logic [CNT_W-1:0] need_rs;
  logic [CNT_W-1:0] need_rt;
  logic             fwd_rs;
  logic             fwd_rt;

  always_comb begin
    need_rs = need_of(id_rs);
    need_rt = need_of(id_rt);
    need    = (need_rs > need_rt) ? need_rs : need_rt;
    fwd_rs  = mem_reg_write && !mem_mem_read && (mem_rd == id_rs) && (id_rs != '0);
    fwd_rt  = mem_reg_write && !mem_mem_read && (mem_rd == id_rt) && (id_rt != '0);
    fwd_a   = fwd_rs ? mem_alu_result : id_rs_data;
    fwd_b   = fwd_rt ? mem_alu_result : id_rt_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage beq/bne interlock: stalls until operands are obtainable, feeds the
// equality comparator and issues the taken decision and IF flush.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_branch,
  input  logic          id_bne,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rd,
  input  logic          mem_reg_write,
  input  logic          mem_mem_read,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_alu_result,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  input  logic          is_equal,
  output logic          stall,
  output logic          branch_taken,
  output logic          flush_if
);

  brs_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] need;
  logic [DW-1:0]    fwd_a;
  logic [DW-1:0]    fwd_b;
  logic             stall_c;
  logic             resolve;

  branch_hazard_detect #(
    .DW (DW),
    .RW (RW)
  ) u_hazard (
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_read   (mem_mem_read),
    .mem_rd         (mem_rd),
    .mem_alu_result (mem_alu_result),
    .need           (need),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    resolve = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (id_branch) begin
          if (need == '0) begin
            resolve = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_d   = need - CNT_W'(1);
            state_d = (need > CNT_W'(1)) ? ST_WAIT : ST_RESOLVE;
          end
        end
      end
      // Counter alone decides when WAIT ends; hazards are not re-checked here.
      ST_WAIT: begin
        if (!id_branch) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
          if (cnt_q <= CNT_W'(1)) state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        resolve = id_branch;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall        = !reset && stall_c;
    branch_taken = !reset && resolve && (is_equal ^ id_bne);
    flush_if     = branch_taken;
    op_a         = reset ? '0 : fwd_a;
    op_b         = reset ? '0 : fwd_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_branch, id_bne;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_rs_data, id_rt_data;
  logic        ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        mem_reg_write, mem_mem_read;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result;
  logic [31:0] op_a, op_b;
  logic        is_equal;
  logic        stall, branch_taken, flush_if;

  int total = 0;
  int bad   = 0;

  branch_resolve_unit #(
    .DW (32),
    .RW (5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_branch      (id_branch),
    .id_bne         (id_bne),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_read   (mem_mem_read),
    .mem_rd         (mem_rd),
    .mem_alu_result (mem_alu_result),
    .op_a           (op_a),
    .op_b           (op_b),
    .is_equal       (is_equal),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .flush_if       (flush_if)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    reset = 1'b0; id_branch = 1'b0; id_bne = 1'b0;
    id_rs = '0; id_rt = '0; id_rs_data = '0; id_rt_data = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = '0;
    mem_alu_result = '0; is_equal = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1; id_branch = 1'b1; id_rs = 5'd3; id_rs_data = 32'd5;
    id_rt = 5'd4; id_rt_data = 32'd5; is_equal = 1'b1;
    ex_reg_write = 1'b1; ex_rd = 5'd3;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b000) begin
      $display("FAIL reset_ctl got=%b want=000", {stall, branch_taken, flush_if}); bad++;
    end
    total++;
    if (op_a !== 32'd0 || op_b !== 32'd0) begin
      $display("FAIL reset_ops got=%0d/%0d want=0/0", op_a, op_b); bad++;
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_no_hazard();
    clear_inputs();
    id_branch = 1'b1; id_rs = 5'd2; id_rt = 5'd3;
    id_rs_data = 32'd24; id_rt_data = 32'd24; is_equal = 1'b1;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b011) begin
      $display("FAIL nohaz_ctl got=%b want=011", {stall, branch_taken, flush_if}); bad++;
    end
    total++;
    if (op_a !== 32'd24 || op_b !== 32'd24) begin
      $display("FAIL nohaz_ops got=%0d/%0d want=24/24", op_a, op_b); bad++;
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b000) begin
      $display("FAIL nohaz_after got=%b want=000", {stall, branch_taken, flush_if}); bad++;
    end
    next_cycle();
  endtask

  task automatic test_ex_alu_fwd();
    clear_inputs();
    id_branch = 1'b1; id_bne = 1'b1; id_rs = 5'd8; id_rt = 5'd9;
    id_rs_data = 32'd1; id_rt_data = 32'd24;
    ex_reg_write = 1'b1; ex_rd = 5'd8;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b100) begin
      $display("FAIL exalu_stall got=%b want=100", {stall, branch_taken, flush_if}); bad++;
    end
    next_cycle();
    ex_reg_write = 1'b0; ex_rd = '0;
    mem_reg_write = 1'b1; mem_rd = 5'd8; mem_alu_result = 32'd52; is_equal = 1'b0;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b011) begin
      $display("FAIL exalu_resolve got=%b want=011", {stall, branch_taken, flush_if}); bad++;
    end
    total++;
    if (op_a !== 32'd52 || op_b !== 32'd24) begin
      $display("FAIL exalu_fwd got=%0d/%0d want=52/24", op_a, op_b); bad++;
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_load_two_stall();
    clear_inputs();
    id_branch = 1'b1; id_rs = 5'd7; id_rt = 5'd9;
    id_rs_data = 32'd78; id_rt_data = 32'd0;
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b100) begin
      $display("FAIL load_stall1 got=%b want=100", {stall, branch_taken, flush_if}); bad++;
    end
    next_cycle();
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd9;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b100) begin
      $display("FAIL load_stall2 got=%b want=100", {stall, branch_taken, flush_if}); bad++;
    end
    next_cycle();
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = '0;
    id_rt_data = 32'd78; is_equal = 1'b1;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b011) begin
      $display("FAIL load_resolve got=%b want=011", {stall, branch_taken, flush_if}); bad++;
    end
    total++;
    if (op_a !== 32'd78 || op_b !== 32'd78) begin
      $display("FAIL load_ops got=%0d/%0d want=78/78", op_a, op_b); bad++;
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    id_branch = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd0;
    mem_reg_write = 1'b1; mem_rd = 5'd0; mem_alu_result = 32'd99;
    is_equal = 1'b1;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b011) begin
      $display("FAIL zero_ctl got=%b want=011", {stall, branch_taken, flush_if}); bad++;
    end
    total++;
    if (op_a !== 32'd0 || op_b !== 32'd0) begin
      $display("FAIL zero_ops got=%0d/%0d want=0/0", op_a, op_b); bad++;
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    id_branch = 1'b1; id_rs = 5'd9; id_rt = 5'd2;
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9;
    @(negedge clk);
    total++;
    if (stall !== 1'b1) begin
      $display("FAIL rstwait_enter got=%b want=1", stall); bad++;
    end
    next_cycle();
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    reset = 1'b1; is_equal = 1'b1;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b000) begin
      $display("FAIL rstwait_during got=%b want=000", {stall, branch_taken, flush_if}); bad++;
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b000) begin
      $display("FAIL rstwait_after got=%b want=000", {stall, branch_taken, flush_if}); bad++;
    end
    next_cycle();
    id_branch = 1'b1; id_rs = 5'd4; id_rt = 5'd5; is_equal = 1'b1;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b011) begin
      $display("FAIL rstwait_idle got=%b want=011", {stall, branch_taken, flush_if}); bad++;
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_squash_in_wait();
    clear_inputs();
    id_branch = 1'b1; id_rs = 5'd6; id_rt = 5'd2;
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd6;
    @(negedge clk);
    total++;
    if (stall !== 1'b1) begin
      $display("FAIL squash_enter got=%b want=1", stall); bad++;
    end
    next_cycle();
    clear_inputs();
    is_equal = 1'b1;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b000) begin
      $display("FAIL squash_drop got=%b want=000", {stall, branch_taken, flush_if}); bad++;
    end
    next_cycle();
    id_branch = 1'b1; id_bne = 1'b1; id_rs = 5'd3; id_rt = 5'd4; is_equal = 1'b0;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b011) begin
      $display("FAIL squash_idle got=%b want=011", {stall, branch_taken, flush_if}); bad++;
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    id_branch = 1'b1; id_rs = 5'd10; id_rt = 5'd11;
    id_rs_data = 32'd0; id_rt_data = 32'd33;
    ex_reg_write = 1'b1; ex_rd = 5'd10;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b100) begin
      $display("FAIL b2b_stall1 got=%b want=100", {stall, branch_taken, flush_if}); bad++;
    end
    next_cycle();
    ex_reg_write = 1'b0; ex_rd = '0;
    mem_reg_write = 1'b1; mem_rd = 5'd10; mem_alu_result = 32'd33; is_equal = 1'b1;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b011 || op_a !== 32'd33) begin
      $display("FAIL b2b_resolve1 got=%b/%0d want=011/33", {stall, branch_taken, flush_if}, op_a); bad++;
    end
    next_cycle();
    // Second branch: MEM load into rs, needs one stall cycle.
    mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd12; mem_alu_result = '0;
    id_rs = 5'd12; id_rt = 5'd13; id_rs_data = 32'd1; id_rt_data = 32'd2; is_equal = 1'b0;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b100) begin
      $display("FAIL b2b_stall2 got=%b want=100", {stall, branch_taken, flush_if}); bad++;
    end
    next_cycle();
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = '0;
    @(negedge clk);
    total++;
    if ({stall, branch_taken, flush_if} !== 3'b000) begin
      $display("FAIL b2b_resolve2 got=%b want=000", {stall, branch_taken, flush_if}); bad++;
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    clear_inputs();
    #1;
    test_reset();
    test_no_hazard();
    test_ex_alu_fwd();
    test_load_two_stall();
    test_zero_reg();
    test_reset_mid_wait();
    test_squash_in_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
